// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb game sound path.
//   state_t      : buzzer arbiter states
//   SRC_*        : bit positions of each sound source in the one-hot grant
//   DEF_CLK_HZ   : default system clock frequency
//   prio()       : arbitration rank of a state (higher wins, IDLE lowest)
//   is_burst()   : state plays a fixed-length tone burst
//   grant_of()   : one-hot grant decode of a state
package bomb_pkg;

  localparam int DEF_CLK_HZ = 1_000_000;

  localparam int SRC_ALARM = 0;
  localparam int SRC_MUSIC = 1;
  localparam int SRC_TICK  = 2;
  localparam int SRC_CLICK = 3;

  typedef enum logic [2:0] {
    IDLE,
    ALARM,
    MUSIC,
    TICK,
    CLICK
  } state_t;

  function automatic logic [2:0] prio(state_t s);
    case (s)
      ALARM:   return 3'd4;
      MUSIC:   return 3'd3;
      TICK:    return 3'd2;
      CLICK:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_burst(state_t s);
    return (s == ALARM) || (s == TICK) || (s == CLICK);
  endfunction

  function automatic logic [3:0] grant_of(state_t s);
    logic [3:0] g;
    g = '0;
    case (s)
      ALARM:   g[SRC_ALARM] = 1'b1;
      MUSIC:   g[SRC_MUSIC] = 1'b1;
      TICK:    g[SRC_TICK]  = 1'b1;
      CLICK:   g[SRC_CLICK] = 1'b1;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/buzzer_arbiter_tone_gen.sv
// Square-wave tone generator shared by all burst sources.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart the tone with wave low (state entry or retrigger)
//   half     : half-period in clock cycles (must be >= 2)
//   wave     : toggle flop output
// The arbiter registers wave once more into the buzzer pad flop, so the first
// half-period is preloaded one cycle short; the pad then rises exactly `half`
// cycles after the load edge and toggles every `half` cycles after that.
module tone_gen #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] half,
  output logic         wave
);

  logic [W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (load) begin
      cnt  <= half - W'(2);
      wave <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= half - W'(1);
      wave <= ~wave;
    end else begin
      cnt  <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, preemptive owner of the single buzzer pad.
//   clk, rst    : clock, synchronous active-high reset
//   mute        : forces buzzer low, arbitration unaffected
//   alarm_req   : pulse, wrong password (1 kHz burst)
//   music_en    : level, music playing
//   music_wave  : music square wave, passed through while granted
//   tick_req    : pulse, countdown second (2 kHz burst)
//   click_req   : pulse, key click (4 kHz burst)
//   buzzer      : registered pad drive
//   grant       : registered one-hot owner {click, tick, music, alarm}
//   busy        : grant nonzero
module buzzer_arbiter
  import bomb_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int ALARM_HALF = 500,
  parameter int ALARM_MS   = 300,
  parameter int TICK_HALF  = 250,
  parameter int TICK_MS    = 50,
  parameter int CLICK_HALF = 125,
  parameter int CLICK_MS   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mute,
  input  logic       alarm_req,
  input  logic       music_en,
  input  logic       music_wave,
  input  logic       tick_req,
  input  logic       click_req,
  output logic       buzzer,
  output logic [3:0] grant,
  output logic       busy
);

  localparam int ALARM_CYC = ALARM_MS * CLK_HZ / 1000;
  localparam int TICK_CYC  = TICK_MS * CLK_HZ / 1000;
  localparam int CLICK_CYC = CLICK_MS * CLK_HZ / 1000;
  localparam int MAX_AT    = (ALARM_CYC > TICK_CYC) ? ALARM_CYC : TICK_CYC;
  localparam int MAX_CYC   = (MAX_AT > CLICK_CYC) ? MAX_AT : CLICK_CYC;
  localparam int MAX_HAT   = (ALARM_HALF > TICK_HALF) ? ALARM_HALF : TICK_HALF;
  localparam int MAX_HALF  = (MAX_HAT > CLICK_HALF) ? MAX_HAT : CLICK_HALF;
  localparam int DW        = $clog2(MAX_CYC + 1);
  localparam int HW        = $clog2(MAX_HALF + 1);

  state_t          state, base, cand, state_next;
  logic            restart, tone_load, wave, buz_src;
  logic [DW-1:0]   dur, len_sel;
  logic [HW-1:0]   half_sel;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    base       = state;
    cand       = IDLE;
    state_next = state;
    restart    = 1'b0;

    // Where the current owner would go on its own; new requests are then
    // judged against this, so a burst ending and a new request on the same
    // edge hand over with no idle gap. dur == 1 is the last granted cycle.
    case (state)
      ALARM, TICK, CLICK: if (dur == DW'(1)) base = music_en ? MUSIC : IDLE;
      MUSIC:              if (!music_en)     base = IDLE;
      default:            ;
    endcase

    if (alarm_req)      cand = ALARM;
    else if (music_en)  cand = MUSIC;
    else if (tick_req)  cand = TICK;
    else if (click_req) cand = CLICK;

    state_next = base;
    if (prio(cand) > prio(base)) begin
      state_next = cand;
      restart    = is_burst(cand);
    end else if (cand == base && is_burst(base)) begin
      restart    = 1'b1;
    end
  end

  assign tone_load = restart || (state_next != state);

  always_comb begin
    len_sel  = '0;
    half_sel = HW'(ALARM_HALF);
    case (state_next)
      ALARM: begin len_sel = DW'(ALARM_CYC); half_sel = HW'(ALARM_HALF); end
      TICK:  begin len_sel = DW'(TICK_CYC);  half_sel = HW'(TICK_HALF);  end
      CLICK: begin len_sel = DW'(CLICK_CYC); half_sel = HW'(CLICK_HALF); end
      default: ;
    endcase
  end

  // Pad source for the cycle after this edge; a reloading tone starts low.
  always_comb begin
    buz_src = 1'b0;
    if (state_next == MUSIC)                      buz_src = music_wave;
    else if (is_burst(state_next) && !tone_load)  buz_src = wave;
  end

  tone_gen #(.W(HW)) u_tone (
    .clk  (clk),
    .rst  (rst),
    .load (tone_load),
    .half (half_sel),
    .wave (wave)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      buzzer <= 1'b0;
      dur    <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_of(state_next);
      buzzer <= mute ? 1'b0 : buz_src;
      if (restart)                   dur <= len_sel;
      else if (!is_burst(state_next)) dur <= '0;
      else                           dur <= dur - DW'(1);
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter with a scaled-down clock so every
// burst fits a short run. A time-window reference model predicts grant, busy
// and buzzer after every rising edge; outputs are compared on the falling edge.
module tb_buzzer_arbiter;

  localparam int CLK_HZ     = 10_000;
  localparam int ALARM_HALF = 20;
  localparam int ALARM_MS   = 300;
  localparam int TICK_HALF  = 10;
  localparam int TICK_MS    = 50;
  localparam int CLICK_HALF = 5;
  localparam int CLICK_MS   = 20;
  localparam int ALARM_CYC  = ALARM_MS * CLK_HZ / 1000;
  localparam int TICK_CYC   = TICK_MS * CLK_HZ / 1000;
  localparam int CLICK_CYC  = CLICK_MS * CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mute = 1'b0;
  logic       alarm_req = 1'b0;
  logic       music_en = 1'b0;
  logic       music_wave = 1'b0;
  logic       tick_req = 1'b0;
  logic       click_req = 1'b0;
  logic       buzzer;
  logic [3:0] grant;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  buzzer_arbiter #(
    .CLK_HZ(CLK_HZ), .ALARM_HALF(ALARM_HALF), .ALARM_MS(ALARM_MS),
    .TICK_HALF(TICK_HALF), .TICK_MS(TICK_MS),
    .CLICK_HALF(CLICK_HALF), .CLICK_MS(CLICK_MS)
  ) dut (
    .clk(clk), .rst(rst), .mute(mute), .alarm_req(alarm_req),
    .music_en(music_en), .music_wave(music_wave), .tick_req(tick_req),
    .click_req(click_req), .buzzer(buzzer), .grant(grant), .busy(busy)
  );

  // Reference model: owner is a source index (0 alarm, 1 music, 2 tick,
  // 3 click, -1 none); a burst owns the pad over the edge window
  // [start_cyc, end_cyc) and its tone is a function of elapsed cycles.
  int         src = -1;
  int         cyc = 0;
  int         start_cyc = 0;
  int         end_cyc = 0;
  logic [3:0] exp_grant = 4'b0;
  logic       exp_buz = 1'b0;

  function automatic int rank(int s);
    return (s < 0) ? 0 : 4 - s;
  endfunction

  function automatic bit burst(int s);
    return (s == 0) || (s == 2) || (s == 3);
  endfunction

  function automatic int len_of(int s);
    return (s == 0) ? ALARM_CYC : (s == 2) ? TICK_CYC : CLICK_CYC;
  endfunction

  function automatic int half_of(int s);
    return (s == 0) ? ALARM_HALF : (s == 2) ? TICK_HALF : CLICK_HALF;
  endfunction

  task automatic model_edge();
    logic [3:0] req;
    int         cand;
    cyc++;
    if (rst) begin
      src       = -1;
      exp_grant = 4'b0;
      exp_buz   = 1'b0;
      return;
    end
    if (burst(src) && cyc >= end_cyc) src = music_en ? 1 : -1;
    else if (src == 1 && !music_en)   src = -1;
    req  = {click_req, tick_req, music_en, alarm_req};
    cand = -1;
    for (int i = 3; i >= 0; i--) if (req[i]) cand = i;
    if (rank(cand) > rank(src) || (cand == src && burst(cand))) begin
      src = cand;
      if (burst(cand)) begin
        start_cyc = cyc;
        end_cyc   = cyc + len_of(cand);
      end
    end
    exp_grant = (src < 0) ? 4'b0 : 4'(1 << src);
    if (mute)            exp_buz = 1'b0;
    else if (src == 1)   exp_buz = music_wave;
    else if (burst(src)) exp_buz = (((cyc - start_cyc) / half_of(src)) % 2) == 1;
    else                 exp_buz = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  // One clock: model follows the edge, outputs compared half a cycle later,
  // then the music wave wanders so pass-through is exercised.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("grant", 32'(grant), 32'(exp_grant));
    check("busy", 32'(busy), 32'(exp_grant != 4'b0));
    check("buzzer", 32'(buzzer), 32'(exp_buz));
    if ($urandom_range(0, 3) == 0) music_wave = ~music_wave;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int rises;
  int hi_grant;
  int buz_hi;
  logic prev_buz;

  initial begin
    @(negedge clk);
    // Reset held two cycles, then idle.
    run(2);
    rst = 1'b0;
    run(5);

    // Single tick burst: length and number of tone periods.
    tick_req = 1'b1;
    rises = 0; hi_grant = 0; prev_buz = 1'b0;
    for (int i = 0; i < TICK_CYC + 10; i++) begin
      step();
      tick_req = 1'b0;
      if (grant == 4'b0100) hi_grant++;
      if (buzzer && !prev_buz) rises++;
      prev_buz = buzzer;
    end
    check("tick_len", 32'(hi_grant), 32'(TICK_CYC));
    check("tick_rises", 32'(rises), 32'(TICK_CYC / (2 * TICK_HALF)));

    // Click and tick together: tick wins, click never plays.
    click_req = 1'b1; tick_req = 1'b1;
    step();
    click_req = 1'b0; tick_req = 1'b0;
    run(TICK_CYC + 5);

    // Retrigger mid-burst, then a new tick on the very last burst cycle.
    tick_req = 1'b1; step(); tick_req = 1'b0;
    run(200);
    tick_req = 1'b1; step(); tick_req = 1'b0;
    run(TICK_CYC - 1);
    tick_req = 1'b1; step(); tick_req = 1'b0;
    run(TICK_CYC + 5);

    // Alarm preempts a running tick; tick is not resumed.
    tick_req = 1'b1; step(); tick_req = 1'b0;
    run(100);
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    run(ALARM_CYC + 20);

    // Music, alarm mid-music, tick ignored, return to music, music off.
    music_en = 1'b1;
    run(50);
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    run(100);
    tick_req = 1'b1; step(); tick_req = 1'b0;
    run(ALARM_CYC);
    tick_req = 1'b1; step(); tick_req = 1'b0;
    run(60);
    music_en = 1'b0;
    run(20);

    // Music rising during a click preempts it.
    click_req = 1'b1; step(); click_req = 1'b0;
    run(30);
    music_en = 1'b1;
    run(40);
    music_en = 1'b0;
    run(10);

    // Muted click: full-length grant, silent pad.
    mute = 1'b1;
    click_req = 1'b1;
    hi_grant = 0; buz_hi = 0;
    for (int i = 0; i < CLICK_CYC + 5; i++) begin
      step();
      click_req = 1'b0;
      if (grant == 4'b1000) hi_grant++;
      if (buzzer) buz_hi++;
    end
    check("mute_click_len", 32'(hi_grant), 32'(CLICK_CYC));
    check("mute_silent", 32'(buz_hi), 32'd0);
    mute = 1'b0;

    // Reset mid-alarm, with a request on the reset edge.
    alarm_req = 1'b1; step(); alarm_req = 1'b0;
    run(137);
    rst = 1'b1; tick_req = 1'b1;
    step();
    rst = 1'b0; tick_req = 1'b0;
    run(10);

    // Randomized traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      alarm_req = ($urandom_range(0, 3999) == 0);
      tick_req  = ($urandom_range(0, 299) == 0);
      click_req = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1499) == 0) music_en = ~music_en;
      if ($urandom_range(0, 499) == 0)  mute = ~mute;
      rst = ($urandom_range(0, 4999) == 0);
      step();
    end
    alarm_req = 1'b0; tick_req = 1'b0; click_req = 1'b0;
    music_en = 1'b0; mute = 1'b0; rst = 1'b0;
    run(ALARM_CYC + 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
